vec_pack: RTL and testbench



---
 rtl/vec_pkg.sv | 30 +++
 rtl/bit_rev.sv | 13 +
 rtl/vec_pack.sv | 131 +++++++++++++
 tb/tb_vec_pack.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector separator / packer pair: geometry
// helpers, FSM state encodings and a generic bit-reversal helper.
package vec_pkg;

  localparam int MAX_BUS_WIDTH = 1024;

  typedef enum logic {FULL, PAD}  sep_state_e;
  typedef enum logic {RUN, FLUSH} pack_state_e;

  function automatic int calc_sub_vec_no(input int vector_width, input int bus_width);
    return (vector_width + bus_width - 1) / bus_width;
  endfunction

  function automatic int calc_delta(input int vector_width, input int bus_width,
                                    input int sub_vec_no);
    return sub_vec_no * bus_width - vector_width;
  endfunction

  // Reverses the low 'width' bits of v; bits above 'width' come back zero.
  function automatic logic [MAX_BUS_WIDTH-1:0] bit_reverse(input logic [MAX_BUS_WIDTH-1:0] v,
                                                          input int width);
    logic [MAX_BUS_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_BUS_WIDTH; i++) begin
      if (i < width) r[i] = v[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_rev.sv
// Parameterised bus bit-reversal: dout[i] = din[WIDTH-1-i]. Pure wiring.
module bit_rev #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign dout[i] = din[WIDTH-1-i];
  end

endmodule

// File: rtl/vec_pack.sv
// Packs per-vector, LSB-padded sub-vectors back into a continuous bus
// stream, stripping the DELTA pad bits from each vector's final word.
module vec_pack
  import vec_pkg::*;
#(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int SUB_VEC_NO   = calc_sub_vec_no(VECTOR_WIDTH, BUS_WIDTH),
  parameter bit REVERSE_OUT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] up_Vector,
  input  logic                 up_Valid,
  input  logic                 up_Last,
  output logic                 up_Ready,
  output logic [BUS_WIDTH-1:0] dn_Vector,
  output logic                 dn_Valid,
  output logic                 dn_Last,
  input  logic                 dn_Ready,
  output logic                 dbg_state
);

  localparam int DELTA = calc_delta(VECTOR_WIDTH, BUS_WIDTH, SUB_VEC_NO);
  localparam int TAIL  = BUS_WIDTH - DELTA;
  localparam int FW    = $clog2(BUS_WIDTH);
  localparam int FW1   = FW + 1;
  localparam int CW    = $clog2(SUB_VEC_NO);

  pack_state_e state, state_nxt;

  logic [BUS_WIDTH-1:0]   r_Acc;
  logic [FW-1:0]          r_Fill;
  logic [CW-1:0]          r_SubVecCntr;
  logic [BUS_WIDTH-1:0]   r_Out;
  logic                   r_OutValid;
  logic                   r_OutLast;

  logic                   slot_free;
  logic                   accept;
  logic                   final_sub;
  logic [FW1-1:0]         n;
  logic [FW1-1:0]         f;
  logic [FW1-1:0]         rem;
  logic                   emit;
  logic                   last_exact;
  logic [BUS_WIDTH-1:0]   mask;
  logic [2*BUS_WIDTH-1:0] cat;

  // Handshakes: a word moves when valid && ready on the same rising edge;
  // valid never waits on ready, and up_Ready depends combinationally on dn_Ready.
  assign slot_free  = !r_OutValid || dn_Ready;
  assign up_Ready   = !rst && (state == RUN) && slot_free;
  assign accept     = up_Valid && up_Ready;

  assign final_sub  = (r_SubVecCntr == CW'(SUB_VEC_NO - 1));
  assign n          = final_sub ? FW1'(TAIL) : FW1'(BUS_WIDTH);
  assign mask       = ~({BUS_WIDTH{1'b1}} >> n);
  // New bits land directly below the r_Fill residue bits already held.
  assign cat        = {r_Acc, {BUS_WIDTH{1'b0}}}
                    | ({up_Vector & mask, {BUS_WIDTH{1'b0}}} >> r_Fill);
  assign f          = {1'b0, r_Fill} + n;
  assign emit       = (f >= FW1'(BUS_WIDTH));
  assign rem        = f - FW1'(BUS_WIDTH);
  assign last_exact = emit && (rem == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept && up_Last && !last_exact) state_nxt = FLUSH;
      FLUSH:   if (slot_free)                        state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_Acc        <= '0;
      r_Fill       <= '0;
      r_SubVecCntr <= '0;
      r_Out        <= '0;
      r_OutValid   <= 1'b0;
      r_OutLast    <= 1'b0;
    end else if (state == RUN) begin
      if (accept) begin
        r_SubVecCntr <= final_sub ? '0 : r_SubVecCntr + CW'(1);
        if (emit) begin
          r_Out      <= cat[2*BUS_WIDTH-1:BUS_WIDTH];
          r_OutValid <= 1'b1;
          r_OutLast  <= up_Last && last_exact;
          r_Acc      <= cat[BUS_WIDTH-1:0];
          r_Fill     <= rem[FW-1:0];
        end else begin
          r_OutValid <= 1'b0;
          r_OutLast  <= 1'b0;
          r_Acc      <= cat[2*BUS_WIDTH-1:BUS_WIDTH];
          r_Fill     <= f[FW-1:0];
        end
      end else if (dn_Ready) begin
        r_OutValid <= 1'b0;
        r_OutLast  <= 1'b0;
      end
    end else if (slot_free) begin
      // Residue is MSB-aligned with zeros below, so it is already padded.
      r_Out      <= r_Acc;
      r_OutValid <= 1'b1;
      r_OutLast  <= 1'b1;
      r_Acc      <= '0;
      r_Fill     <= '0;
    end
  end

  if (REVERSE_OUT) begin : g_rev
    bit_rev #(.WIDTH(BUS_WIDTH)) u_bit_rev (
      .din  (r_Out),
      .dout (dn_Vector)
    );
  end else begin : g_pass
    assign dn_Vector = r_Out;
  end

  assign dn_Valid  = r_OutValid;
  assign dn_Last   = r_OutLast && r_OutValid;
  assign dbg_state = (state == FLUSH);

endmodule

// File: tb/tb_vec_pack.sv
// Directed bench for vec_pack: 8-bit bus, 12-bit vectors (padding path)
// and 16-bit vectors (pass-through path).
module tb_vec_pack;

  logic       clk;
  logic       rst;

  logic [7:0] a_up_vector;
  logic       a_up_valid;
  logic       a_up_last;
  logic       a_up_ready;
  logic [7:0] a_dn_vector;
  logic       a_dn_valid;
  logic       a_dn_last;
  logic       a_dn_ready;
  logic       a_dbg;

  logic [7:0] b_up_vector;
  logic       b_up_valid;
  logic       b_up_last;
  logic       b_up_ready;
  logic [7:0] b_dn_vector;
  logic       b_dn_valid;
  logic       b_dn_last;
  logic       b_dn_ready;
  logic       b_dbg;

  int total;
  int bad;

  logic [8:0] exp_q[$];

  vec_pack #(.BUS_WIDTH(8), .VECTOR_WIDTH(12), .REVERSE_OUT(1'b1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .up_Vector (a_up_vector),
    .up_Valid  (a_up_valid),
    .up_Last   (a_up_last),
    .up_Ready  (a_up_ready),
    .dn_Vector (a_dn_vector),
    .dn_Valid  (a_dn_valid),
    .dn_Last   (a_dn_last),
    .dn_Ready  (a_dn_ready),
    .dbg_state (a_dbg)
  );

  vec_pack #(.BUS_WIDTH(8), .VECTOR_WIDTH(16), .REVERSE_OUT(1'b1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .up_Vector (b_up_vector),
    .up_Valid  (b_up_valid),
    .up_Last   (b_up_last),
    .up_Ready  (b_up_ready),
    .dn_Vector (b_dn_vector),
    .dn_Valid  (b_dn_valid),
    .dn_Last   (b_dn_last),
    .dn_Ready  (b_dn_ready),
    .dbg_state (b_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [7:0] v, input logic valid, input logic last);
    a_up_vector = v;
    a_up_valid  = valid;
    a_up_last   = last;
  endtask

  task automatic drive_b(input logic [7:0] v, input logic valid, input logic last);
    b_up_vector = v;
    b_up_valid  = valid;
    b_up_last   = last;
  endtask

  // One 12-bit vector w0,w1 with dn_Ready held high; exercises the FLUSH bubble.
  task automatic pack_one(input logic [7:0] w0, input logic [7:0] w1);
    exp_q.push_back({1'b0, 8'hD5});
    exp_q.push_back({1'b1, 8'h03});
    drive_a(w0, 1'b1, 1'b0);
    #1 chk("one_rdy0", a_up_ready, 1);
    tick();
    chk("one_v0", a_dn_valid, 1);
    chk("one_d0", a_dn_vector, 8'hD5);
    chk("one_l0", a_dn_last, 0);
    drive_a(w1, 1'b1, 1'b1);
    #1 chk("one_rdy1", a_up_ready, 1);
    tick();
    chk("one_bubble_v", a_dn_valid, 0);
    chk("one_bubble_rdy", a_up_ready, 0);
    chk("one_flush_st", a_dbg, 1);
    drive_a(8'h00, 1'b0, 1'b0);
    tick();
    chk("one_v1", a_dn_valid, 1);
    chk("one_d1", a_dn_vector, 8'h03);
    chk("one_l1", a_dn_last, 1);
    chk("one_rdy2", a_up_ready, 1);
    tick();
    chk("one_idle_v", a_dn_valid, 0);
    chk("one_drained", exp_q.size(), 0);
  endtask

  // scoreboard: every delivered word of dut_a is matched against exp_q in order
  always @(negedge clk) begin
    if (!rst && a_dn_valid && a_dn_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", {a_dn_last, a_dn_vector}, 9'h1FF);
      end else begin
        chk("sb_word", {a_dn_last, a_dn_vector}, exp_q.pop_front());
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive_a(8'h00, 1'b0, 1'b0);
    drive_b(8'h00, 1'b0, 1'b0);
    a_dn_ready = 1'b1;
    b_dn_ready = 1'b1;

    // reset state
    tick();
    tick();
    chk("rst_up_ready", a_up_ready, 0);
    chk("rst_dn_valid", a_dn_valid, 0);
    chk("rst_dn_last", a_dn_last, 0);
    chk("rst_dn_vector", a_dn_vector, 0);
    chk("rst_state", a_dbg, 0);
    chk("rst_b_up_ready", b_up_ready, 0);
    rst = 1'b0;
    #1 chk("rel_up_ready", a_up_ready, 1);
    tick();

    // single vector
    pack_one(8'hAB, 8'hC0);

    // two vectors back to back, no flush
    exp_q.push_back({1'b0, 8'hD5});
    exp_q.push_back({1'b0, 8'hB3});
    exp_q.push_back({1'b1, 8'hF7});
    drive_a(8'hAB, 1'b1, 1'b0);
    tick();
    chk("two_d0", a_dn_vector, 8'hD5);
    drive_a(8'hC0, 1'b1, 1'b0);
    #1 chk("two_rdy1", a_up_ready, 1);
    tick();
    chk("two_gap_v", a_dn_valid, 0);
    chk("two_gap_rdy", a_up_ready, 1);
    chk("two_gap_st", a_dbg, 0);
    drive_a(8'hDE, 1'b1, 1'b0);
    tick();
    chk("two_d1", a_dn_vector, 8'hB3);
    chk("two_l1", a_dn_last, 0);
    drive_a(8'hF0, 1'b1, 1'b1);
    tick();
    chk("two_d2", a_dn_vector, 8'hF7);
    chk("two_l2", a_dn_last, 1);
    chk("two_st", a_dbg, 0);
    drive_a(8'h00, 1'b0, 1'b0);
    tick();
    chk("two_idle_v", a_dn_valid, 0);
    chk("two_drained", exp_q.size(), 0);

    // dirty padding in the final sub-vector
    pack_one(8'hAB, 8'hCF);

    // backpressure for 3 cycles after the first word
    exp_q.push_back({1'b0, 8'hD5});
    exp_q.push_back({1'b0, 8'hB3});
    exp_q.push_back({1'b1, 8'hF7});
    drive_a(8'hAB, 1'b1, 1'b0);
    tick();
    chk("bp_d0", a_dn_vector, 8'hD5);
    a_dn_ready = 1'b0;
    drive_a(8'hC0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_hold_rdy", a_up_ready, 0);
      chk("bp_hold_v", a_dn_valid, 1);
      chk("bp_hold_d", a_dn_vector, 8'hD5);
      chk("bp_hold_l", a_dn_last, 0);
      tick();
    end
    a_dn_ready = 1'b1;
    #1 chk("bp_rel_rdy", a_up_ready, 1);
    tick();
    chk("bp_gap_v", a_dn_valid, 0);
    drive_a(8'hDE, 1'b1, 1'b0);
    tick();
    chk("bp_d1", a_dn_vector, 8'hB3);
    drive_a(8'hF0, 1'b1, 1'b1);
    tick();
    chk("bp_d2", a_dn_vector, 8'hF7);
    chk("bp_l2", a_dn_last, 1);
    drive_a(8'h00, 1'b0, 1'b0);
    tick();
    chk("bp_drained", exp_q.size(), 0);

    // async reset between 0xDE and 0xF0; the pending 0xB3 word is discarded
    exp_q.push_back({1'b0, 8'hD5});
    drive_a(8'hAB, 1'b1, 1'b0);
    tick();
    drive_a(8'hC0, 1'b1, 1'b0);
    tick();
    drive_a(8'hDE, 1'b1, 1'b0);
    tick();
    chk("ar_pre_v", a_dn_valid, 1);
    chk("ar_pre_d", a_dn_vector, 8'hB3);
    rst = 1'b1;
    drive_a(8'h00, 1'b0, 1'b0);
    #1 chk("ar_v", a_dn_valid, 0);
    chk("ar_l", a_dn_last, 0);
    chk("ar_d", a_dn_vector, 0);
    chk("ar_rdy", a_up_ready, 0);
    tick();
    rst = 1'b0;
    #1 chk("ar_rel_rdy", a_up_ready, 1);
    chk("ar_drained", exp_q.size(), 0);
    tick();
    pack_one(8'hAB, 8'hC0);

    // pass-through configuration: no padding, no bubble
    drive_b(8'h12, 1'b1, 1'b0);
    #1 chk("pt_rdy0", b_up_ready, 1);
    tick();
    chk("pt_v0", b_dn_valid, 1);
    chk("pt_d0", b_dn_vector, 8'h48);
    chk("pt_l0", b_dn_last, 0);
    drive_b(8'h34, 1'b1, 1'b1);
    #1 chk("pt_rdy1", b_up_ready, 1);
    tick();
    chk("pt_v1", b_dn_valid, 1);
    chk("pt_d1", b_dn_vector, 8'h2C);
    chk("pt_l1", b_dn_last, 1);
    chk("pt_st", b_dbg, 0);
    chk("pt_rdy2", b_up_ready, 1);
    drive_b(8'h00, 1'b0, 1'b0);
    tick();
    chk("pt_idle_v", b_dn_valid, 0);
    chk("pt_idle_st", b_dbg, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
